op_f_sweep_checker: RTL and testbench

//  Drives the other end of the 4-in/2-out OP_F logic interface: sweeps all 16 (a,b,c,d)

---
 rtl/op_f_sweep_checker.sv | 126 ++++++++++++
 tb/tb_op_f_sweep_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/op_f_sweep_checker.sv
// op_f_sweep_checker: self-test sequencer that sweeps all 16 OP_F input vectors,
// compares y/z against golden equations and reports mismatch count and first failing vector.
`default_nettype none

module op_f_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_c,
  output logic             drv_d,
  input  logic             obs_y,
  input  logic             obs_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] mismatch_cnt,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec
);

  localparam logic [1:0]       S_IDLE      = 2'd0;
  localparam logic [1:0]       S_RUN       = 2'd1;
  localparam logic [1:0]       S_DONE      = 2'd2;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] CNT_MAX     = '1;

  logic [1:0]       state_q,  state_d;
  logic [3:0]       vec_q,    vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] cnt_q,    cnt_d;
  logic             ffv_q,    ffv_d;
  logic [3:0]       ffvec_q,  ffvec_d;
  logic             pass_q,   pass_d;

  logic y_exp, z_exp, sample, miss;

  // Golden OP_F equations, evaluated on the vector currently driven.
  assign y_exp  = vec_q[0] | (vec_q[3] & ~vec_q[2] & vec_q[1]);
  assign z_exp  = (vec_q[2] & vec_q[0]) | (vec_q[3] & ~vec_q[1] & vec_q[0]);
  assign sample = (state_q == S_RUN) && (settle_q == SETTLE_LAST);
  assign miss   = sample && ((obs_y != y_exp) || (obs_z != z_exp));

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          vec_d    = 4'd0;
          settle_d = 4'd0;
          cnt_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = 4'd0;
          pass_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (sample) begin
          settle_d = 4'd0;
          if (miss) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          if (vec_q == 4'hF) begin
            state_d = S_DONE;
            pass_d  = (cnt_d == '0);
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= 4'd0;
      settle_q <= 4'd0;
      cnt_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= 4'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      pass_q   <= pass_d;
    end
  end

  // vec_q keeps its final value in DONE, so the drive is gated to RUN only.
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign drv_a            = busy & vec_q[3];
  assign drv_b            = busy & vec_q[2];
  assign drv_c            = busy & vec_q[1];
  assign drv_d            = busy & vec_q[0];
  assign mismatch_cnt     = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

`default_nettype wire

// File: tb/tb_op_f_sweep_checker.sv
// tb_op_f_sweep_checker: scoreboard bench driving two checker instances against
// behavioural OP_F devices with selectable faults.
`default_nettype none

module tb_op_f_sweep_checker;

  typedef struct {
    int cnt;
    int ffv;
    int ffvec;
    int pass;
    int len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  int   mode_a = 0, mode_b = 0;
  int   sel = 0;
  int   total = 0, bad = 0;
  exp_t q[$];

  logic da_a, db_a, dc_a, dd_a, y_a, z_a, busy_a, done_a, pass_a, ffv_a;
  logic da_b, db_b, dc_b, dd_b, y_b, z_b, busy_b, done_b, pass_b, ffv_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;
  logic [3:0] ffvec_a, ffvec_b;

  always #5 clk = ~clk;

  // Behavioural device under check: 0 golden, 1 z stuck-0, 2 y stuck-1, 3 both inverted.
  function automatic logic [1:0] opf(input int mode, input logic [3:0] v);
    logic y, z;
    y = v[0] | (v[3] & ~v[2] & v[1]);
    z = (v[2] & v[0]) | (v[3] & ~v[1] & v[0]);
    case (mode)
      1: z = 1'b0;
      2: y = 1'b1;
      3: begin y = ~y; z = ~z; end
      default: ;
    endcase
    return {y, z};
  endfunction

  assign {y_a, z_a} = opf(mode_a, {da_a, db_a, dc_a, dd_a});
  assign {y_b, z_b} = opf(mode_b, {da_b, db_b, dc_b, dd_b});

  op_f_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .drv_a(da_a), .drv_b(db_a), .drv_c(dc_a), .drv_d(dd_a),
    .obs_y(y_a), .obs_z(z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_cnt(cnt_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  op_f_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .drv_a(da_b), .drv_b(db_b), .drv_c(dc_b), .drv_d(dd_b),
    .obs_y(y_b), .obs_z(z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_cnt(cnt_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  logic [3:0] s_drv, s_ffvec;
  logic [4:0] s_cnt;
  logic       s_busy, s_done, s_pass, s_ffv;
  assign s_drv   = (sel != 0) ? {da_b, db_b, dc_b, dd_b} : {da_a, db_a, dc_a, dd_a};
  assign s_busy  = (sel != 0) ? busy_b : busy_a;
  assign s_done  = (sel != 0) ? done_b : done_a;
  assign s_pass  = (sel != 0) ? pass_b : pass_a;
  assign s_ffv   = (sel != 0) ? ffv_b  : ffv_a;
  assign s_ffvec = (sel != 0) ? ffvec_b : ffvec_a;
  assign s_cnt   = (sel != 0) ? {2'b00, cnt_b} : cnt_a;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int mode, input int errw, input int settle);
    exp_t e;
    logic [1:0] g, o;
    e = '{cnt: 0, ffv: 0, ffvec: 0, pass: 0, len: 16 * (settle + 1)};
    for (int v = 0; v < 16; v++) begin
      g = opf(0, 4'(v));
      o = opf(mode, 4'(v));
      if (g != o) begin
        if (e.ffv == 0) begin
          e.ffv   = 1;
          e.ffvec = v;
        end
        if (e.cnt < (1 << errw) - 1) e.cnt++;
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic set_start(input int inst, input logic val);
    if (inst != 0) start_b = val;
    else           start_a = val;
  endtask

  task automatic sweep(input int inst, input int mode, input bit poke_run);
    exp_t e;
    int   n, per;
    sel = inst;
    if (inst != 0) mode_b = mode;
    else           mode_a = mode;
    q.push_back(model(mode, (inst != 0) ? 3 : 5, (inst != 0) ? 0 : 1));
    per = (inst != 0) ? 1 : 2;
    @(posedge clk); #1;
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!s_busy) break;
      chk("drv_vec", int'(s_drv), n / per);
      if (n == 0) begin
        chk("clr_cnt", int'(s_cnt), 0);
        chk("clr_ffv", int'(s_ffv), 0);
        chk("clr_done", int'(s_done), 0);
        chk("clr_pass", int'(s_pass), 0);
      end
      if (poke_run && n == 3) set_start(inst, 1'b1);
      if (poke_run && n == 4) set_start(inst, 1'b0);
      n++;
    end
    e = q.pop_front();
    chk("busy_len", n, e.len);
    chk("done", int'(s_done), 1);
    chk("cnt", int'(s_cnt), e.cnt);
    chk("ffv", int'(s_ffv), e.ffv);
    chk("ffvec", int'(s_ffvec), e.ffvec);
    chk("pass", int'(s_pass), e.pass);
    chk("drv_idle", int'(s_drv), 0);
    repeat (3) @(negedge clk);
    chk("hold_done", int'(s_done), 1);
    chk("hold_cnt", int'(s_cnt), e.cnt);
    chk("hold_ffvec", int'(s_ffvec), e.ffvec);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, int'({da_a, db_a, dc_a, dd_a, busy_a, done_a, pass_a, ffv_a, ffvec_a, cnt_a}), 0);
    chk({tag, "_b"}, int'({da_b, db_b, dc_b, dd_b, busy_b, done_b, pass_b, ffv_b, ffvec_b, cnt_b}), 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    sweep(0, 0, 1'b0);  // golden, SETTLE=1
    sweep(0, 1, 1'b0);  // z stuck-0
    sweep(0, 2, 1'b0);  // y stuck-1
    sweep(1, 3, 1'b0);  // both inverted, ERR_W=3 saturation
    sweep(1, 0, 1'b1);  // SETTLE=0 rerun from DONE with start poked in RUN
    sweep(1, 0, 1'b0);

    // Asynchronous reset mid-sweep
    sel = 0;
    mode_a = 2;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
